// File: rtl/hazard_control.sv
// Pipeline hazard unit: operand forwarding, load-use and branch stalls, plus a
// small FSM that freezes the pipeline while a multi-beat vector memory access drains.
module hazard_control #(
    parameter int LANES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] writeregE,
    input  logic [4:0] writeregM,
    input  logic [4:0] writeregW,
    input  logic       regwriteE,
    input  logic       regwriteM,
    input  logic       regwriteW,
    input  logic       memtoregE,
    input  logic       memtoregM,
    input  logic [1:0] branchD,
    input  logic       vmemM,
    input  logic       mem_ready,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       stallM,
    output logic       flushE,
    output logic       flushW,
    output logic       forwardaD,
    output logic       forwardbD,
    output logic [1:0] forwardaE,
    output logic [1:0] forwardbE,
    output logic       vbusy,
    output logic [3:0] vbeat
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] XFER = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] LAST_BEAT = 4'(LANES - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] beat_q, beat_d;
    logic       lwstall, branchstall, vstall;

    // Register 0 is hard-wired to zero, so it never creates a dependency.
    function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] dst);
        return (src != 5'd0) && (src == dst);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic [4:0] wm, input logic rwm,
                                           input logic [4:0] ww, input logic rww);
        if (rwm && reg_hit(src, wm))
            return 2'b10;
        else if (rww && reg_hit(src, ww))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        forwardaE = fwd_sel(rsE, writeregM, regwriteM, writeregW, regwriteW);
        forwardbE = fwd_sel(rtE, writeregM, regwriteM, writeregW, regwriteW);
        forwardaD = regwriteM && reg_hit(rsD, writeregM);
        forwardbD = regwriteM && reg_hit(rtD, writeregM);
    end

    always_comb begin
        lwstall = memtoregE && regwriteE &&
                  (reg_hit(rtE, rsD) || reg_hit(rtE, rtD));
        branchstall = (branchD != 2'd0) &&
                      ((regwriteE && (reg_hit(rsD, writeregE) || reg_hit(rtD, writeregE))) ||
                       (memtoregM && (reg_hit(rsD, writeregM) || reg_hit(rtD, writeregM))));
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (vmemM) begin
                    state_d = XFER;
                    beat_d  = 4'd0;
                end
            end
            XFER: begin
                if (mem_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                        beat_d  = 4'd0;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            // One unstalled cycle lets the vector instruction leave M before IDLE looks at vmemM again.
            DONE: begin
                state_d = IDLE;
                beat_d  = 4'd0;
            end
            default: begin
                state_d = IDLE;
                beat_d  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            beat_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // The stall is raised in the trigger cycle itself, before the FSM has left IDLE.
    assign vstall = ((state_q == IDLE) && vmemM) || (state_q == XFER);

    always_comb begin
        if (vstall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushE = 1'b0;
            flushW = 1'b1;
        end else begin
            stallF = lwstall || branchstall;
            stallD = lwstall || branchstall;
            flushE = lwstall || branchstall;
            stallE = 1'b0;
            stallM = 1'b0;
            flushW = 1'b0;
        end
    end

    assign vbusy = (state_q == XFER);
    assign vbeat = (state_q == XFER) ? beat_q : 4'd0;

endmodule

// File: tb/tb_hazard_control.sv
// Self-checking bench for hazard_control: table of combinational hazard vectors
// followed by hand-written vector-transfer and mid-transfer reset sequences.
module tb_hazard_control;

    typedef struct packed {
        logic [4:0] rsD, rtD, rsE, rtE, wE, wM, wW;
        logic       rwE, rwM, rwW, mtE, mtM;
        logic [1:0] br;
        logic       vm, mr;
    } in_t;

    typedef struct packed {
        logic [5:0] st;     // {stallF, stallD, stallE, stallM, flushE, flushW}
        logic [1:0] fd;     // {forwardaD, forwardbD}
        logic [1:0] fa;
        logic [1:0] fb;
        logic       vb;
        logic [3:0] beat;
    } out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  o;
    } vec_t;

    localparam logic [5:0] VST = 6'b111101;
    localparam logic [5:0] LUS = 6'b110010;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic [1:0] branchD;
    logic       vmemM, mem_ready;
    logic       stallF, stallD, stallE, stallM, flushE, flushW, forwardaD, forwardbD;
    logic [1:0] forwardaE, forwardbE;
    logic       vbusy;
    logic [3:0] vbeat;

    int n_vec = 0;
    int n_bad = 0;

    out_t  exp_q[$];
    string name_q[$];
    vec_t  tbl[$];
    out_t  act;

    always #5 clk = ~clk;

    hazard_control #(.LANES(8)) dut (
        .clk(clk), .reset(reset),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .vmemM(vmemM), .mem_ready(mem_ready),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushE(flushE), .flushW(flushW),
        .forwardaD(forwardaD), .forwardbD(forwardbD),
        .forwardaE(forwardaE), .forwardbE(forwardbE),
        .vbusy(vbusy), .vbeat(vbeat)
    );

    assign act = {stallF, stallD, stallE, stallM, flushE, flushW, forwardaD, forwardbD,
                  forwardaE, forwardbE, vbusy, vbeat};

    function automatic in_t vin(input int a_rsD, input int a_rtD, input int a_rsE, input int a_rtE,
                                input int a_wE, input int a_wM, input int a_wW,
                                input bit a_rwE, input bit a_rwM, input bit a_rwW,
                                input bit a_mtE, input bit a_mtM, input int a_br,
                                input bit a_vm, input bit a_mr);
        in_t v;
        v.rsD = 5'(a_rsD); v.rtD = 5'(a_rtD); v.rsE = 5'(a_rsE); v.rtE = 5'(a_rtE);
        v.wE = 5'(a_wE); v.wM = 5'(a_wM); v.wW = 5'(a_wW);
        v.rwE = a_rwE; v.rwM = a_rwM; v.rwW = a_rwW; v.mtE = a_mtE; v.mtM = a_mtM;
        v.br = 2'(a_br); v.vm = a_vm; v.mr = a_mr;
        return v;
    endfunction

    function automatic out_t ex(input logic [5:0] st, input int fd, input int fa, input int fb,
                                input bit vb, input int beat);
        out_t o;
        o.st = st; o.fd = 2'(fd); o.fa = 2'(fa); o.fb = 2'(fb); o.vb = vb; o.beat = 4'(beat);
        return o;
    endfunction

    task automatic drive(input in_t v);
        rsD = v.rsD; rtD = v.rtD; rsE = v.rsE; rtE = v.rtE;
        writeregE = v.wE; writeregM = v.wM; writeregW = v.wW;
        regwriteE = v.rwE; regwriteM = v.rwM; regwriteW = v.rwW;
        memtoregE = v.mtE; memtoregM = v.mtM;
        branchD = v.br; vmemM = v.vm; mem_ready = v.mr;
    endtask

    task automatic expect_out(input string n, input out_t e);
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic check_pop();
        out_t  e;
        string n;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard: got empty queue, required an entry");
        end else begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            n_vec++;
            if (act !== e) begin
                n_bad++;
                $display("FAIL %s: got %05h required %05h", n, act, e);
            end else begin
                $display("ok   %s: %05h", n, act);
            end
        end
    endtask

    // Drive just after a rising edge, check at the following falling edge.
    task automatic apply(input string n, input in_t v, input out_t e);
        @(posedge clk);
        #1;
        drive(v);
        expect_out(n, e);
        @(negedge clk);
        check_pop();
    endtask

    initial begin
        in_t Z, V, L;
        Z = vin(0,0,0,0,0,0,0, 0,0,0,0,0, 0, 0,0);
        V = vin(0,0,0,0,0,0,0, 0,0,0,0,0, 0, 1,1);

        tbl.push_back('{"zero",     Z,                                          ex(6'd0,0,0,0,0,0)});
        tbl.push_back('{"fwdA_M",   vin(0,0,5,0,0,5,5, 0,1,1,0,0, 0,0,0),       ex(6'd0,0,2,0,0,0)});
        tbl.push_back('{"fwdA_W",   vin(0,0,5,0,0,5,5, 0,0,1,0,0, 0,0,0),       ex(6'd0,0,1,0,0,0)});
        tbl.push_back('{"fwdA_r0",  vin(0,0,0,0,0,5,5, 0,0,1,0,0, 0,0,0),       ex(6'd0,0,0,0,0,0)});
        tbl.push_back('{"fwdB_M",   vin(0,0,0,9,0,9,9, 0,1,1,0,0, 0,0,0),       ex(6'd0,0,0,2,0,0)});
        tbl.push_back('{"fwdB_W",   vin(0,0,0,9,0,9,9, 0,0,1,0,0, 0,0,0),       ex(6'd0,0,0,1,0,0)});
        tbl.push_back('{"fwd_mix",  vin(0,0,3,9,0,3,9, 0,1,1,0,0, 0,0,0),       ex(6'd0,0,2,1,0,0)});
        tbl.push_back('{"fwdD_a",   vin(4,6,0,0,0,4,0, 0,1,0,0,0, 0,0,0),       ex(6'd0,2,0,0,0,0)});
        tbl.push_back('{"fwdD_b",   vin(4,6,0,0,0,6,0, 0,1,0,0,0, 0,0,0),       ex(6'd0,1,0,0,0,0)});
        tbl.push_back('{"fwdD_r0",  vin(0,0,0,0,0,0,0, 0,1,0,0,0, 0,0,0),       ex(6'd0,0,0,0,0,0)});
        tbl.push_back('{"lw_rs",    vin(7,0,0,7,0,0,0, 1,0,0,1,0, 0,0,0),       ex(LUS,0,0,0,0,0)});
        tbl.push_back('{"lw_rt",    vin(0,7,0,7,0,0,0, 1,0,0,1,0, 0,0,0),       ex(LUS,0,0,0,0,0)});
        tbl.push_back('{"lw_r0",    vin(0,0,0,0,0,0,0, 1,0,0,1,0, 0,0,0),       ex(6'd0,0,0,0,0,0)});
        tbl.push_back('{"lw_nomem", vin(7,0,0,7,0,0,0, 1,0,0,0,0, 0,0,0),       ex(6'd0,0,0,0,0,0)});
        tbl.push_back('{"br_A",     vin(0,3,0,0,3,0,0, 1,0,0,0,0, 1,0,0),       ex(LUS,0,0,0,0,0)});
        tbl.push_back('{"br_A_r0",  vin(0,0,0,0,0,0,0, 1,0,0,0,0, 1,0,0),       ex(6'd0,0,0,0,0,0)});
        tbl.push_back('{"br_B",     vin(8,0,0,0,0,8,0, 0,0,0,0,1, 2,0,0),       ex(LUS,0,0,0,0,0)});
        tbl.push_back('{"br_none",  vin(0,3,0,0,3,0,0, 1,0,0,0,0, 0,0,0),       ex(6'd0,0,0,0,0,0)});
        tbl.push_back('{"br_norw",  vin(0,3,0,0,3,0,0, 0,0,0,0,0, 1,0,0),       ex(6'd0,0,0,0,0,0)});
        tbl.push_back('{"br_B_rt",  vin(0,8,0,0,0,8,0, 0,1,0,0,1, 3,0,0),       ex(LUS,1,0,0,0,0)});

        reset = 1'b0;
        drive(Z);
        #3;
        expect_out("reset_state", ex(6'd0,0,0,0,0,0));
        check_pop();
        @(negedge clk);
        reset = 1'b1;

        foreach (tbl[k]) apply(tbl[k].name, tbl[k].i, tbl[k].o);

        // Eight back-to-back beats: 9 stalled cycles, then an unstalled DONE cycle.
        apply("v8_trigger", V, ex(VST,0,0,0,0,0));
        for (int k = 0; k < 8; k++) apply($sformatf("v8_beat%0d", k), V, ex(VST,0,0,0,1,k));
        apply("v8_done", V, ex(6'd0,0,0,0,0,0));
        apply("v8_idle0", Z, ex(6'd0,0,0,0,0,0));
        apply("v8_idle1", Z, ex(6'd0,0,0,0,0,0));

        // Gapped beats with a load-use hazard present the whole time.
        L = vin(7,0,0,7,0,0,0, 1,0,0,1,0, 0, 1,0);
        apply("vg_trigger", L, ex(VST,0,0,0,0,0));
        for (int k = 1; k <= 16; k++) begin
            L.mr = (k % 2 == 0);
            apply($sformatf("vg_xfer%0d", k), L, ex(VST,0,0,0,1,(k-1)/2));
        end
        L.mr = 1'b0;
        apply("vg_done_lw", L, ex(LUS,0,0,0,0,0));
        apply("vg_idle", Z, ex(6'd0,0,0,0,0,0));

        // Asynchronous reset mid-transfer, then a fresh transfer from beat 0.
        apply("vr_trigger", V, ex(VST,0,0,0,0,0));
        for (int k = 0; k <= 4; k++) apply($sformatf("vr_beat%0d", k), V, ex(VST,0,0,0,1,k));
        #2;
        reset = 1'b0;
        #1;
        expect_out("vr_reset_async", ex(VST,0,0,0,0,0));
        check_pop();
        drive(Z);
        #1;
        expect_out("vr_reset_zero", ex(6'd0,0,0,0,0,0));
        check_pop();
        @(negedge clk);
        reset = 1'b1;
        apply("vr_retrigger", V, ex(VST,0,0,0,0,0));
        apply("vr_rebeat0", V, ex(VST,0,0,0,1,0));
        apply("vr_rebeat1", V, ex(VST,0,0,0,1,1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_control.md
HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 Parameter LANES, default 8: number of memory beats in one vector memory access; legal range 2..16.
REQ-002 Port clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port reset  in  1  asynchronous, active-low reset.
REQ-004 Ports rsD, rtD  in  5 each  source register fields of the instruction in Decode.
REQ-005 Ports rsE, rtE  in  5 each  source register fields of the instruction in Execute.
REQ-006 Ports writeregE, writeregM, writeregW  in  5 each  destination register of E, M and W.
REQ-007 Ports regwriteE, regwriteM, regwriteW, memtoregE, memtoregM  in  1 each  stage control bits from the controller pipeline.
REQ-008 Port branchD  in  2  branch type in Decode; 0 means no branch.
REQ-009 Port vmemM  in  1  the instruction in M is a vector load or store.
REQ-010 Port mem_ready  in  1  data memory accepted or returned one beat this cycle.
REQ-011 Ports stallF, stallD, stallE, stallM  out  1 each  hold the corresponding pipeline register.
REQ-012 Ports flushE, flushW  out  1 each  insert a bubble into E or W.
REQ-013 Ports forwardaD, forwardbD  out  1 each  forward M result to the Decode branch comparator.
REQ-014 Ports forwardaE, forwardbE  out  2 each  forwarding select: 00 = register file, 01 = W, 10 = M.
REQ-015 Port vbusy  out  1  vector transfer in progress.
REQ-016 Port vbeat  out  4  current beat index of the transfer.

Function
REQ-017 forwardaE SHALL be 10 if rsE != 0, rsE == writeregM and regwriteM; otherwise 01 if rsE != 0, rsE == writeregW and regwriteW; otherwise 00. forwardbE is the same using rtE; M has priority over W.
REQ-018 forwardaD SHALL be (rsD != 0) & (rsD == writeregM) & regwriteM; forwardbD is the same using rtD.
REQ-019 lwstall SHALL be memtoregE & regwriteE & (rtE == rsD | rtE == rtD), with rtE != 0.
REQ-020 branchstall SHALL be (branchD != 0) & (A | B), where:
- A = regwriteE & writeregE in {rsD, rtD}
- B = memtoregM & writeregM in {rsD, rtD}
- register 0 never matches.
REQ-021 The FSM SHALL have states IDLE, XFER and DONE, with a 4-bit beat counter.
REQ-022 IDLE -> XFER when vmemM = 1; the counter clears to 0.
REQ-023 In XFER, the counter SHALL increment on each mem_ready. XFER -> DONE when mem_ready = 1 and counter == LANES-1. XFER holds indefinitely while mem_ready = 0.
REQ-024 DONE -> IDLE unconditionally; DONE ignores vmemM, so the same instruction is not re-triggered.
REQ-025 vstall SHALL be (state == IDLE & vmemM) | (state == XFER).
REQ-026 While vstall = 1, the block SHALL assert:
- stallF = stallD = stallE = stallM = 1
- flushW = 1
- flushE = 0
- lwstall and branchstall are ignored.
REQ-027 While vstall = 0: stallF = stallD = flushE = lwstall | branchstall, and stallE = stallM = flushW = 0.
REQ-028 vbusy SHALL be (state == XFER); vbeat SHALL equal the counter, and 0 outside XFER.
REQ-029 Stall and forwarding outputs are combinational from state and inputs; only state and counter are registered.
REQ-030 Total vector stall SHALL be exactly (cycles until the LANES-th mem_ready) + 1 cycles; with mem_ready held at 1, this is LANES+1 cycles.

Reset
REQ-031 reset = 0 SHALL immediately force state to IDLE and the counter to 0, including mid-XFER; any partial transfer is abandoned.
REQ-032 With reset active and all inputs 0, every output SHALL be 0.
REQ-033 After reset release, the first transition SHALL occur on the first rising clk edge.

Verification
REQ-034 Forwarding: rsE = 5, writeregM = 5, regwriteM = 1, writeregW = 5, regwriteW = 1 -> forwardaE = 10; then regwriteM = 0 -> forwardaE = 01; then rsE = 0 -> forwardaE = 00.
REQ-035 Load-use: memtoregE = regwriteE = 1, rtE = 7, rsD = 7 -> stallF = stallD = flushE = 1 for one cycle, stallE = 0.
REQ-036 Branch hazard: branchD = 1, regwriteE = 1, writeregE = 3, rtD = 3 -> stallF = stallD = flushE = 1; writeregE = 0 with rtD = 0 -> no stall.
REQ-037 Vector transfer, LANES = 8, mem_ready = 1 constantly, vmemM = 1:
- stall outputs high for 9 cycles
- vbeat steps 0..7
- DONE cycle has all stalls 0
- no re-entry to XFER.
REQ-038 Vector transfer with mem_ready toggling 1,0,1,0...: 8 beats counted, 16 XFER cycles, vbeat holds during gaps; a coincident lwstall does not assert flushE.
REQ-039 reset = 0 at vbeat = 4 -> vbusy = 0 and vbeat = 0 immediately; after release with vmemM = 1, a new transfer starts from vbeat = 0.
